// File: rtl/doc_uart_sender.sv
// doc_uart_sender: walks the ROWS x COLS text document through the shared
// read port, turns blank cells into spaces, optionally closes each row with
// CR/LF and hands every byte to the UART TX over a valid/ready handshake.
module doc_uart_sender #(
    parameter int COLS      = 20,
    parameter int ROWS      = 15,
    parameter bit EMIT_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic       start,
    input  logic       abort,
    input  logic       mem_busy,
    output logic       rd_en,
    output logic [8:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    localparam logic [7:0] CHR_SPACE = 8'h20;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_CR,
        S_LF,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       row_end;

    // Next-state logic: cell sequencing, row wrap and abort override.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tx_data_d = tx_data_q;
        row_end   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // The editor owns the port while mem_busy is high; rd_data is
                // not ours to sample, so wait here with the request held.
                if (!mem_busy) begin
                    tx_data_d = (rd_data == 8'h00) ? CHR_SPACE : rd_data;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (col_q != LAST_COL) begin
                        col_d   = col_q + 5'd1;
                        state_d = S_FETCH;
                    end else if (EMIT_CRLF) begin
                        tx_data_d = CHR_CR;
                        state_d   = S_CR;
                    end else begin
                        row_end = 1'b1;
                    end
                end
            end
            S_CR: begin
                if (tx_ready) begin
                    tx_data_d = CHR_LF;
                    state_d   = S_LF;
                end
            end
            S_LF: begin
                if (tx_ready) begin
                    row_end = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (row_end) begin
            if (row_q == LAST_ROW) begin
                state_d = S_DONE;
            end else begin
                row_d   = row_q + 4'd1;
                col_d   = '0;
                state_d = S_FETCH;
            end
        end

        // Abort wins over everything, including a byte accepted this cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            tx_data_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign rd_en    = (state_q == S_FETCH);
    assign rd_addr  = {row_q, col_q};
    assign tx_data  = tx_data_q;
    assign tx_valid = (state_q == S_SEND) || (state_q == S_CR) || (state_q == S_LF);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_doc_uart_sender.sv
// Bench for doc_uart_sender: a document array feeds two instances (with and
// without CR/LF); the expected byte stream is derived from the byte index
// within a dump and the document contents.
module tb_doc_uart_sender;

    localparam int COLS = 20;
    localparam int ROWS = 15;
    localparam logic [7:0] EDIT_VAL = 8'h5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, mem_busy = 1'b0, tx_ready = 1'b0;
    logic start2 = 1'b0;

    logic       rd_en, tx_valid, busy, done;
    logic [8:0] rd_addr;
    logic [7:0] rd_data, tx_data;
    logic       rd_en2, tx_valid2, busy2, done2;
    logic [8:0] rd_addr2;
    logic [7:0] rd_data2, tx_data2;

    logic [7:0] mem [ROWS][COLS];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        rd_data = 8'hEE;
        if (rd_addr[8:5] < ROWS && rd_addr[4:0] < COLS) rd_data = mem[rd_addr[8:5]][rd_addr[4:0]];
    end

    always_comb begin
        rd_data2 = 8'hEE;
        if (rd_addr2[8:5] < ROWS && rd_addr2[4:0] < COLS) rd_data2 = mem[rd_addr2[8:5]][rd_addr2[4:0]];
    end

    doc_uart_sender #(.COLS(COLS), .ROWS(ROWS), .EMIT_CRLF(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_busy(mem_busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    doc_uart_sender #(.COLS(COLS), .ROWS(ROWS), .EMIT_CRLF(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .mem_busy(1'b0),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(1'b1),
        .busy(busy2), .done(done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte k of a dump: cells row-major, blanks as spaces, optional CR/LF per row.
    function automatic logic [7:0] exp_byte(input int k, input bit crlf);
        int w = crlf ? COLS + 2 : COLS;
        int r = k / w;
        int p = k % w;
        if (p == COLS)     return 8'h0D;
        if (p == COLS + 1) return 8'h0A;
        return (mem[r][p] == 8'h00) ? 8'h20 : mem[r][p];
    endfunction

    // kind 0: all blank; 1: any byte, ~25% blank; 2: printable, ~25% blank.
    task automatic fill_mem(input int kind);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                logic [7:0] v;
                v = 8'h00;
                if (kind == 1) v = 8'($urandom_range(0, 255));
                if (kind == 2) v = 8'($urandom_range(32, 126));
                if ($urandom_range(0, 3) == 0) v = 8'h00;
                mem[r][c] = v;
            end
        end
    endtask

    // Monitor for the CR/LF instance: stream order, hold, port yield, timing.
    int         acc = 0, s_cyc = 0, done_cnt = 0, done_cyc = -1, rd_cyc = -1, val_cyc = -1;
    logic [8:0] first_addr = '0;
    logic [7:0] log_b [330];
    initial begin
        logic       p_hold, p_fetch_busy;
        logic [7:0] p_data;
        logic [8:0] p_addr;
        p_hold = 1'b0; p_fetch_busy = 1'b0; p_data = '0; p_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p_hold = 1'b0;
                p_fetch_busy = 1'b0;
            end else begin
                if (p_hold) begin
                    check("hold_valid", tx_valid, 1'b1);
                    check("hold_data", tx_data, p_data);
                end
                if (p_fetch_busy) begin
                    check("yield_rd_en", rd_en, 1'b1);
                    check("yield_no_capture", tx_valid, 1'b0);
                    check("yield_addr", rd_addr, p_addr);
                end
                if (start && !busy) begin
                    acc = 0; s_cyc = cyc; rd_cyc = -1; val_cyc = -1;
                end
                if (rd_en && rd_cyc < 0) begin
                    rd_cyc = cyc - s_cyc;
                    first_addr = rd_addr;
                end
                if (tx_valid && val_cyc < 0) val_cyc = cyc - s_cyc;
                if (rd_en) check("addr_range", (rd_addr[4:0] < COLS) && (rd_addr[8:5] < ROWS), 1'b1);
                if (tx_valid && tx_ready && !abort) begin
                    check("byte_in_dump", acc < 330, 1'b1);
                    if (acc < 330) begin
                        check("byte", tx_data, exp_byte(acc, 1'b1));
                        log_b[acc] = tx_data;
                    end
                    acc++;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc - s_cyc;
                    check("count_at_done", acc, 330);
                end
                p_hold       = tx_valid && !tx_ready && !abort;
                p_data       = tx_data;
                p_fetch_busy = rd_en && mem_busy && !abort;
                p_addr       = rd_addr;
            end
        end
    end

    // Monitor for the instance without line breaks (tx_ready tied high).
    int         acc2 = 0, done2_cnt = 0, done2_cyc = -1, s2_cyc = 0;
    logic [8:0] last_addr2 = '0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (start2 && !busy2) begin
                acc2 = 0; s2_cyc = cyc;
            end
            if (rd_en2) last_addr2 = rd_addr2;
            if (tx_valid2) begin
                check("nocrlf_in_dump", acc2 < 300, 1'b1);
                if (acc2 < 300) check("nocrlf_byte", tx_data2, exp_byte(acc2, 1'b0));
                check("nocrlf_no_break", (tx_data2 != 8'h0D) && (tx_data2 != 8'h0A), 1'b1);
                acc2++;
            end
            if (done2) begin
                done2_cnt++;
                done2_cyc = cyc - s2_cyc;
            end
        end
    end

    // mode 0: ready high, port free. 1: 5-cycle stall at byte 3 plus a
    // 3-cycle editor write at {2,7}. 2: random ready/mem_busy, stray start.
    task automatic run_dump(input int mode);
        bit fin = 0, stalled = 0, edited = 0;
        int stall_left = 0, edit_left = 0;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0; tx_ready = 1'b1; mem_busy = 1'b0;
        for (int t = 0; t < 5000 && !fin; t++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; tx_ready = 1'b1; mem_busy = 1'b0;
            if (done) begin
                fin = 1;
            end else if (mode == 1) begin
                if (stall_left > 0) begin
                    tx_ready = 1'b0; stall_left--;
                end else if (!stalled && tx_valid && acc == 3) begin
                    tx_ready = 1'b0; stall_left = 4; stalled = 1;
                end
                if (edit_left > 0) begin
                    mem_busy = 1'b1; edit_left--;
                end else if (!edited && rd_en && rd_addr == {4'd2, 5'd7}) begin
                    mem_busy = 1'b1; edit_left = 2; edited = 1;
                    mem[2][7] = EDIT_VAL;
                end
            end else if (mode == 2) begin
                tx_ready = ($urandom_range(0, 9) < 7);
                mem_busy = ($urandom_range(0, 9) < 3);
                if (t == 200) start = 1'b1;
            end
        end
        check("dump_finished", fin, 1'b1);
        @(posedge clk); #1;
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
    endtask

    task automatic run_abort();
        bit fired = 0;
        int dc = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; tx_ready = 1'b1; mem_busy = 1'b0;
        for (int t = 0; t < 2000 && !fired; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (tx_valid && acc == 100) begin
                abort = 1'b1; fired = 1;
            end
        end
        check("abort_fired", fired, 1'b1);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_tx_valid", tx_valid, 1'b0);
        check("abort_rd_en", rd_en, 1'b0);
        check("abort_addr", rd_addr, 9'd0);
        check("abort_byte_not_counted", acc, 100);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, dc);
    endtask

    task automatic run_reset();
        bit hit = 0;
        int dc = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; tx_ready = 1'b1; mem_busy = 1'b0;
        for (int t = 0; t < 2000 && !hit; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (tx_valid && acc == 50) hit = 1;
        end
        check("reset_point_reached", hit, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("arst_tx_valid", tx_valid, 1'b0);
        check("arst_rd_en", rd_en, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_tx_data", tx_data, 8'h00);
        check("arst_rd_addr", rd_addr, 9'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_reset_idle_valid", tx_valid, 1'b0);
            check("post_reset_idle_busy", busy, 1'b0);
        end
        check("reset_no_done", done_cnt, dc);
    endtask

    initial begin
        bit f;
        int dc;
        fill_mem(0);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx_valid", tx_valid, 1'b0);
        check("reset_rd_en", rd_en, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_rd_addr", rd_addr, 9'd0);
        rst = 1'b1;

        // Single 'A' in the corner, everything else blank.
        fill_mem(0);
        mem[0][0] = 8'h41;
        dc = done_cnt;
        run_dump(0);
        check("d1_done_pulses", done_cnt, dc + 1);
        check("d1_done_cycle", done_cyc, 631);
        check("d1_rd_en_cycle", rd_cyc, 1);
        check("d1_tx_valid_cycle", val_cyc, 2);
        check("d1_bytes", acc, 330);
        check("d1_first", log_b[0], 8'h41);
        check("d1_blank", log_b[1], 8'h20);
        check("d1_col19", log_b[19], 8'h20);
        check("d1_cr", log_b[20], 8'h0D);
        check("d1_lf", log_b[21], 8'h0A);
        check("d1_row1", log_b[22], 8'h20);

        // Back-pressure at byte 3 and an editor write at {2,7}.
        fill_mem(1);
        dc = done_cnt;
        run_dump(1);
        check("d2_done_pulses", done_cnt, dc + 1);
        check("d2_done_cycle", done_cyc, 639);
        check("d2_edited_byte", log_b[51], EDIT_VAL);
        check("d2_bytes", acc, 330);

        // Random handshake and port contention, stray start mid-dump.
        fill_mem(1);
        dc = done_cnt;
        run_dump(2);
        check("d3_done_pulses", done_cnt, dc + 1);
        check("d3_bytes", acc, 330);

        // Abort at byte 100, then a clean restart from address 0.
        fill_mem(1);
        run_abort();
        dc = done_cnt;
        run_dump(0);
        check("restart_first_addr", first_addr, 9'd0);
        check("restart_done_cycle", done_cyc, 631);
        check("restart_bytes", acc, 330);
        check("restart_done_pulses", done_cnt, dc + 1);

        // Asynchronous reset in the middle of a dump.
        run_reset();

        // Instance without line breaks.
        fill_mem(2);
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        f = 0;
        for (int t = 0; t < 2000 && !f; t++) begin
            @(posedge clk); #1;
            if (done2) f = 1;
        end
        check("nocrlf_finished", f, 1'b1);
        @(posedge clk); #1;
        check("nocrlf_bytes", acc2, 300);
        check("nocrlf_done_pulses", done2_cnt, 1);
        check("nocrlf_done_cycle", done2_cyc, 601);
        check("nocrlf_last_addr", last_addr2, {4'd14, 5'd19});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/doc_uart_sender.md
# doc_uart_sender

Controller that streams the 20×15 text document to a UART transmitter when the user presses send. It sequences the document RAM's shared read port, yields to editor writes on that port, and maps blank cells to spaces. It also inserts CR/LF at each row end and hands bytes to the TX with a valid/ready handshake. It sits between the debounced send button, the document memory and the UART TX.

## Interface
- COLS, 20: columns per row; column field of the address is 5 bits.
- ROWS, 15: rows; row field of the address is 4 bits.
- EMIT_CRLF, 1: 1 appends 0x0D, 0x0A after each row; 0 emits no line breaks.
- clk  in  1  system clock; the block's single clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse (one-pulsed send button); begins a dump.
- abort  in  1  level; cancels a dump in progress.
- mem_busy  in  1  editor owns the document port this cycle (its write enable); the block must not sample.
- rd_en  out  1  document read request; high only in FETCH.
- rd_addr  out  9  {row[3:0], col[4:0]} document address.
- rd_data  in  8  document read data; combinational from rd_addr.
- tx_data  out  8  byte to UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts tx_data this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a full dump.

## Operation
- States: IDLE, FETCH, SEND, CR, LF, DONE. Registers: row (4b), col (5b), tx_data (8b).
- IDLE:
  - start=1 → row=0, col=0, go to FETCH.
  - All other inputs are ignored.
- FETCH:
  - rd_en=1, rd_addr={row,col}.
  - mem_busy=1 → stay in FETCH, no capture.
  - Otherwise latch tx_data=(rd_data==0 ? 8'h20 : rd_data) and go to SEND.
- SEND: tx_valid=1; hold until tx_ready. Then:
  - col<COLS-1 → col+1, go to FETCH.
  - col==COLS-1 and EMIT_CRLF → go to CR.
  - col==COLS-1 and no CRLF → end-of-row step (below).
- CR: tx_data=8'h0D, tx_valid=1. On tx_ready → go to LF.
- LF: tx_data=8'h0A, tx_valid=1. On tx_ready → end-of-row step.
- End-of-row step:
  - row==ROWS-1 → go to DONE.
  - Otherwise row+1, col=0, go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE.
- start while busy=1 is ignored; there is no queuing.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; row and col are cleared.
  - No done pulse.
  - abort outranks a coincident tx_ready; the controller does not count that byte.
- Byte count per full dump: ROWS×(COLS+2)=330 with CRLF; ROWS×COLS=300 without.
- The address never exceeds {ROWS-1, COLS-1}; columns 20..31 are never read.

## Timing
- Reset values: tx_valid=0, rd_en=0, busy=0, done=0, tx_data=8'h00, rd_addr=0; state=IDLE.
- Start latency: start in cycle 0 → FETCH (rd_en=1) in cycle 1 → tx_valid=1 in cycle 2 when mem_busy=0.
- Each mem_busy cycle in FETCH adds exactly one cycle.
- While tx_valid=1 and tx_ready=0, tx_data is held stable.
- tx_valid drops only the cycle after acceptance or on abort.
- Per-byte cost with tx_ready tied high: 2 cycles per character (FETCH+SEND), 1 each for CR and LF.
- A full CRLF dump with tx_ready=1 and mem_busy=0 lasts 15×(40+2)=630 cycles from FETCH entry to DONE.
- done is asserted in cycle 631 after start's cycle 0 and lasts one cycle; busy falls in the same cycle done falls.
- rst asserted mid-dump forces reset values immediately (asynchronous). There is no done pulse, and no byte is pending after release.

## Test plan
- Document cell (0,0)=0x41, rest 0, tx_ready=1 → first byte 0x41, then 19×0x20, 0x0D, 0x0A. Total 330 bytes; done pulses once, in cycle 631.
- tx_ready held low 5 cycles at byte 3 → tx_data and tx_valid stay constant for those cycles. The byte order is unchanged.
- mem_busy high 3 cycles during FETCH at address {2,7} → rd_en stays high and no capture occurs. The byte sent equals the RAM content after the editor write.
- EMIT_CRLF=0 → exactly 300 bytes with no 0x0D/0x0A. The last address read is {14,19}.
- abort at byte 100 with a coincident tx_ready → IDLE next cycle, tx_valid=0, no done. A later start restarts at address 0.
- start pulsed mid-dump → no effect on sequence. rst low mid-dump → all outputs go to reset values asynchronously.
